// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch: instruction fetch stage feeding the decoder.
//
// Keeps the fetch PC and issues one word request at a time to the memory port.
// Each returned word is predicted (JAL always taken, conditional branches via
// the BHT or static backward-taken) and pushed into a small FIFO together with
// its PC and prediction bit. The decoder pops from the FIFO head. A redirect
// from the ROB (jp_wrong) empties the FIFO and restarts fetch at jp_target.
//
// Build option: INST_FETCH_BHT_EN
//    defined   : 2-bit saturating BHT indexed by pc[BHT_IDX_W+1:2], trained by
//                br_commit / br_pc / br_taken.
//    undefined : no BHT; branches predicted taken when the offset is negative.
//
// Ports:
//    clk, rst_n            clock, asynchronous active-low reset
//    rdy                   global enable; low freezes all state
//    jp_wrong, jp_target   mispredict redirect and corrected PC
//    mem_req, mem_addr     registered word request (held until mem_valid)
//    mem_valid, mem_data   one-cycle response with the requested word
//    stall_IF              decoder back-pressure; blocks the pop
//    ins_flag              FIFO non-empty
//    ins, jp_flag, jp_pc   head word, head predicted-taken, head PC
//    br_commit, br_pc,     retired conditional branch outcome (BHT update)
//    br_taken
// ----------------------------------------------------------------------------
// state  | meaning
// S_IDLE | no request outstanding; issue one when the FIFO has room
// S_WAIT | request issued, waiting for mem_valid
// S_DRAIN| request outstanding but flushed; its response is dropped
// ----------------------------------------------------------------------------
module inst_fetch #(
   parameter int QUEUE_DEPTH_LOG = 3,
   parameter int BHT_IDX_W       = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic        jp_wrong,
   input  logic [31:0] jp_target,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_valid,
   input  logic [31:0] mem_data,
   input  logic        stall_IF,
   output logic        ins_flag,
   output logic [31:0] ins,
   output logic        jp_flag,
   output logic [31:0] jp_pc,
   input  logic        br_commit,
   input  logic [31:0] br_pc,
   input  logic        br_taken
);

   localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

   state_t                     state;
   logic [31:0]                pc;
   logic [QUEUE_DEPTH_LOG-1:0] head;
   logic [QUEUE_DEPTH_LOG-1:0] tail;
   logic [QUEUE_DEPTH_LOG:0]   count;

   logic [31:0]                q_ins  [DEPTH];
   logic [31:0]                q_pc   [DEPTH];
   logic [DEPTH-1:0]           q_pred;

   logic        push;
   logic        pop;
   logic        full;
   logic        pred;
   logic        br_pred;
   logic [31:0] next_pc;
   logic [6:0]  opcode;
   logic [31:0] jal_off;
   logic [31:0] br_off;

   assign opcode  = mem_data[6:0];
   assign jal_off = {{11{mem_data[31]}}, mem_data[31], mem_data[19:12],
                     mem_data[20], mem_data[30:21], 1'b0};
   assign br_off  = {{19{mem_data[31]}}, mem_data[31], mem_data[7],
                     mem_data[30:25], mem_data[11:8], 1'b0};

`ifdef INST_FETCH_BHT_EN
   localparam int BHT_N = 1 << BHT_IDX_W;

   logic [1:0]           bht [BHT_N];
   logic [BHT_IDX_W-1:0] look_idx;
   logic [BHT_IDX_W-1:0] upd_idx;
   logic                 unused_br_pc;

   assign look_idx     = pc[BHT_IDX_W+1:2];
   assign upd_idx      = br_pc[BHT_IDX_W+1:2];
   assign unused_br_pc = ^{br_pc[31:BHT_IDX_W+2], br_pc[1:0]};
   // Lookup reads the registered counter, so a same-cycle update is not seen.
   assign br_pred      = bht[look_idx][1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
      end else if (rdy && br_commit) begin
         if (br_taken) begin
            if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
         end else begin
            if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
         end
      end
   end
`else
   logic unused_bht;

   assign unused_bht = ^{br_commit, br_pc, br_taken, pc[BHT_IDX_W+1:2]};
   // Static backward-taken: sign bit of the branch offset.
   assign br_pred    = mem_data[31];
`endif

   always_comb begin
      pred    = 1'b0;
      next_pc = pc + 32'd4;
      if (opcode == 7'd111) begin
         pred    = 1'b1;
         next_pc = pc + jal_off;
      end else if (opcode == 7'd99) begin
         pred = br_pred;
         if (br_pred) next_pc = pc + br_off;
      end
   end

   assign ins_flag = (count != '0);
   // Only checked in S_IDLE where nothing is outstanding, so count alone
   // covers count + outstanding and an accepted response always has a slot.
   assign full     = count[QUEUE_DEPTH_LOG];
   assign push     = rdy && !jp_wrong && (state == S_WAIT) && mem_valid;
   assign pop      = rdy && ins_flag && !stall_IF && !jp_wrong;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else if (rdy) begin
         if (jp_wrong) begin
            pc    <= jp_target;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            if (state != S_IDLE) begin
               // A response landing together with the flush completes the
               // request; only a still-pending one needs draining.
               if (mem_valid) begin
                  mem_req <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  state   <= S_DRAIN;
               end
            end
         end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: ;
            endcase
            case (state)
               S_IDLE: begin
                  if (!full) begin
                     mem_req  <= 1'b1;
                     mem_addr <= pc;
                     state    <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (mem_valid) begin
                     mem_req <= 1'b0;
                     pc      <= next_pc;
                     state   <= S_IDLE;
                  end
               end
               S_DRAIN: begin
                  if (mem_valid) begin
                     mem_req <= 1'b0;
                     state   <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_ins[tail]  <= mem_data;
         q_pc[tail]   <= pc;
         q_pred[tail] <= pred;
      end
   end

   assign ins     = ins_flag ? q_ins[head]  : '0;
   assign jp_pc   = ins_flag ? q_pc[head]   : '0;
   assign jp_flag = ins_flag ? q_pred[head] : 1'b0;

endmodule

// File: tb/tb_inst_fetch.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch: directed bench for inst_fetch.
// A small memory model answers each request two cycles after mem_req rises;
// expected addresses, head fields and predictions are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rdy;
   logic        jp_wrong;
   logic [31:0] jp_target;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_data;
   logic        stall_IF;
   logic        ins_flag;
   logic [31:0] ins;
   logic        jp_flag;
   logic [31:0] jp_pc;
   logic        br_commit;
   logic [31:0] br_pc;
   logic        br_taken;

   int n_checks = 0;
   int n_fail   = 0;

   localparam int LAT = 2;

   logic [31:0] mem [256];
   int          wait_cnt;
   logic        req_q;
   logic        req_rise;

   localparam logic [31:0] W_NOP  = 32'h0000_0013;
   localparam logic [31:0] W_JAL  = 32'h0400_006F;  // jal x0, +0x40
   localparam logic [31:0] W_BNEG = 32'hFE00_0CE3;  // beq x0,x0,-8
   localparam logic [31:0] W_BPOS = 32'h0000_0463;  // beq x0,x0,+8

   inst_fetch #(.QUEUE_DEPTH_LOG(3), .BHT_IDX_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rdy       (rdy),
      .jp_wrong  (jp_wrong),
      .jp_target (jp_target),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_valid (mem_valid),
      .mem_data  (mem_data),
      .stall_IF  (stall_IF),
      .ins_flag  (ins_flag),
      .ins       (ins),
      .jp_flag   (jp_flag),
      .jp_pc     (jp_pc),
      .br_commit (br_commit),
      .br_pc     (br_pc),
      .br_taken  (br_taken)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock; then the memory model decides what to drive for the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      req_rise  = mem_req && !req_q;
      req_q     = mem_req;
      if (mem_req && rdy) begin
         wait_cnt++;
         if (wait_cnt == LAT) begin
            mem_valid = 1'b1;
            mem_data  = mem[mem_addr[9:2]];
            wait_cnt  = 0;
         end
      end else begin
         wait_cnt = 0;
      end
   endtask

   task automatic next_fetch(input string tag, input logic [31:0] exp_addr);
      int   n    = 0;
      logic seen = 1'b0;
      while (!seen && n < 40) begin
         tick();
         n++;
         seen = req_rise;
      end
      check({tag, "_req"}, 32'(seen), 32'd1);
      check({tag, "_addr"}, mem_addr, exp_addr);
   endtask

   task automatic branch_case(input string tag, input logic [31:0] word,
                              input logic exp_flag, input logic [31:0] exp_next);
      mem[8]    = word;
      jp_wrong  = 1'b1;
      jp_target = 32'h20;
      tick();
      jp_wrong  = 1'b0;
      next_fetch({tag, "_br"}, 32'h20);
      next_fetch({tag, "_next"}, exp_next);
      check({tag, "_pc"}, jp_pc, 32'h20);
      check({tag, "_flag"}, 32'(jp_flag), 32'(exp_flag));
      check({tag, "_ins"}, ins, word);
   endtask

   task automatic train(input logic taken, input int times);
      br_commit = 1'b1;
      br_pc     = 32'h20;
      br_taken  = taken;
      repeat (times) tick();
      br_commit = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_pcs [8];
      int          rises;
      int          n;

      exp_pcs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h50, 32'h54, 32'h58};
      for (int i = 0; i < 256; i++) mem[i] = W_NOP;
      mem[4] = W_JAL;

      rst_n = 1'b0; rdy = 1'b0; jp_wrong = 1'b0; jp_target = '0;
      mem_valid = 1'b0; mem_data = '0; stall_IF = 1'b1;
      br_commit = 1'b0; br_pc = '0; br_taken = 1'b0;
      wait_cnt = 0; req_q = 1'b0; req_rise = 1'b0;

      #23;
      check("rst_ins_flag", 32'(ins_flag), 32'd0);
      check("rst_ins", ins, 32'd0);
      check("rst_jp_flag", 32'(jp_flag), 32'd0);
      check("rst_jp_pc", jp_pc, 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      check("frozen_mem_req", 32'(mem_req), 32'd0);
      check("frozen_ins_flag", 32'(ins_flag), 32'd0);
      rdy = 1'b1;

      // First fetch: push visible one cycle after mem_valid.
      next_fetch("f0", 32'h0);
      tick();
      check("f0_flag_pre", 32'(ins_flag), 32'd0);
      check("f0_req_held", 32'(mem_req), 32'd1);
      tick();
      check("f0_flag", 32'(ins_flag), 32'd1);
      check("f0_jp_pc", jp_pc, 32'h0);
      check("f0_jp_flag", 32'(jp_flag), 32'd0);
      check("f0_ins", ins, W_NOP);
      check("f0_req_drop", 32'(mem_req), 32'd0);

      // Sequential fetch, JAL at 0x10 jumps to 0x50, then fill under stall.
      for (int i = 1; i < 8; i++) next_fetch($sformatf("fill%0d", i), exp_pcs[i]);
      rises = 0;
      repeat (10) begin
         tick();
         if (req_rise) rises++;
      end
      check("full_no_req", 32'(rises), 32'd0);
      check("full_req_low", 32'(mem_req), 32'd0);
      check("full_flag", 32'(ins_flag), 32'd1);
      check("full_head", jp_pc, 32'h0);

      // Release stall: one pop per cycle in order, fetch resumes at 0x5C.
      stall_IF = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("pop%0d_flag", i), 32'(ins_flag), 32'd1);
         check($sformatf("pop%0d_pc", i), jp_pc, exp_pcs[i]);
         check($sformatf("pop%0d_pred", i), 32'(jp_flag), (i == 4) ? 32'd1 : 32'd0);
         if (i == 4) check("pop_jal_ins", ins, W_JAL);
         tick();
      end
      check("resume_flag", 32'(ins_flag), 32'd1);
      check("resume_head", jp_pc, 32'h5C);
      stall_IF = 1'b1;

      // Redirect with a request outstanding; its late response is dropped.
      n = 0;
      while (!(mem_req && !mem_valid) && n < 40) begin
         tick();
         n++;
      end
      check("outstanding_seen", 32'(mem_req && !mem_valid), 32'd1);
      jp_wrong  = 1'b1;
      jp_target = 32'h200;
      tick();
      jp_wrong  = 1'b0;
      check("flush_empty", 32'(ins_flag), 32'd0);
      check("flush_req_held", 32'(mem_req), 32'd1);
      tick();
      check("drain_no_push", 32'(ins_flag), 32'd0);
      check("drain_req_drop", 32'(mem_req), 32'd0);
      next_fetch("redirect", 32'h200);

`ifdef INST_FETCH_BHT_EN
      branch_case("bht_cold", W_BNEG, 1'b0, 32'h24);
      train(1'b1, 2);
      branch_case("bht_taken", W_BNEG, 1'b1, 32'h18);
      branch_case("bht_fwd", W_BPOS, 1'b1, 32'h28);
      train(1'b0, 3);
      branch_case("bht_untrain", W_BNEG, 1'b0, 32'h24);
`else
      branch_case("static_fwd", W_BPOS, 1'b0, 32'h24);
      branch_case("static_bwd", W_BNEG, 1'b1, 32'h18);
      train(1'b1, 2);
      branch_case("static_ignore", W_BPOS, 1'b0, 32'h24);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
